// File: rtl/tdm_demux_4_if.sv
// tdm_demux_4_if: bundle between an interleaved 4-slot sample source and the
// lane demultiplexer.
//   din / din_valid / frame_sync : sample stream and slot-0 marker (source side)
//   dout / dout_valid            : assembled 4-lane frame and its strobe
//   slot / locked / sync_err     : alignment status
// master = stream source / frame consumer, slave = demultiplexer.
interface tdm_demux_4_if #(
  parameter int W = 1
);
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] dout;
  logic           dout_valid;
  logic [1:0]     slot;
  logic           locked;
  logic           sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_4.sv
// tdm_demux_4: time-division 1-to-4 demultiplexer.
// Takes one W-bit stream carrying lanes 0..3 interleaved in fixed slot order,
// collects each slot into a shadow lane register and publishes all four lanes
// at once as a parallel frame.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : tdm_demux_4_if.slave (din/din_valid/frame_sync in;
//          dout/dout_valid/slot/locked/sync_err out)
// Alignment is acquired on the first frame_sync and then free-running; a
// frame_sync seen away from slot 0 realigns and flags sync_err.

// One shadow lane: load wins over clear so a realign can load lane 0 while
// clearing the others with a single mask.
module tdm_demux_4_lane #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (wr)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module tdm_demux_4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux_4_if.slave   bus
);
  // Slot 3 is never stored: it goes straight from din into dout on the
  // completing edge, so only lanes 0..2 need shadow registers.
  localparam int NUM_SHADOW = 3;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                             state_q, state_d;
  logic [1:0]                         slot_q, slot_d;
  logic [NUM_SHADOW-1:0]              wr, clr;
  logic                               frame_d, err_d;
  logic [NUM_SHADOW-1:0][W-1:0]       lane_q;
  logic [4*W-1:0]                     dout_q;
  logic                               dout_valid_q, sync_err_q;

  // Shadow lane array
  for (genvar k = 0; k < NUM_SHADOW; k++) begin : g_lane
    tdm_demux_4_lane #(.W(W)) u_lane (
      .clk (clk),
      .rst (rst),
      .wr  (wr[k]),
      .clr (clr[k]),
      .d   (bus.din),
      .q   (lane_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr      = '0;
    clr     = '0;
    frame_d = 1'b0;
    err_d   = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          // Everything before the first frame_sync is dropped.
          if (bus.frame_sync) begin
            wr[0]   = 1'b1;
            clr     = 3'b110;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync && slot_q != 2'd0) begin
            // Misplaced sync: drop the partial frame and restart at slot 0.
            // Checked before completion so a sync on slot 3 never emits a frame.
            wr[0]  = 1'b1;
            clr    = 3'b110;
            slot_d = 2'd1;
            err_d  = 1'b1;
          end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd0:    wr[0]   = 1'b1;
              2'd1:    wr[1]   = 1'b1;
              2'd2:    wr[2]   = 1'b1;
              default: frame_d = 1'b1;
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= 2'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      dout_valid_q <= frame_d;
      sync_err_q   <= err_d;
      // dout only moves on a full frame, so partial frames are never visible.
      if (frame_d) dout_q <= {bus.din, lane_q};
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.sync_err   = sync_err_q;
endmodule
